// File: rtl/decode_ctrl_pipe.sv
// Decode stage for a RISC-V style front end: turns the opcode of an accepted
// instruction into a registered control bundle, splits atomics into a read and
// a write micro-op, and keeps a saturating count of illegal instructions.
module decode_ctrl_pipe #(
    parameter int EN_CSR    = 1,
    parameter int EN_ATOMIC = 1,
    parameter int AMO_SPLIT = 1,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic                 stall_compressed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 reg_write,
    output logic                 mem_write,
    output logic                 branch,
    output logic                 alu_src,
    output logic                 jump,
    output logic                 lui,
    output logic                 auipc,
    output logic                 jal,
    output logic                 r_type,
    output logic                 csr_type,
    output logic                 is_atomic,
    output logic                 invalid_inst,
    output logic [1:0]           mem_csr_to_reg,
    output logic [1:0]           alu_op,
    output logic                 uop_phase,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_AMO    = 7'b0101111;

    typedef enum logic {RUN, AMO_WR} state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       jump;
        logic       lui;
        logic       auipc;
        logic       jal;
        logic       r_type;
        logic       csr_type;
        logic       is_atomic;
        logic       invalid_inst;
        logic [1:0] mem_csr_to_reg;
        logic [1:0] alu_op;
        logic       uop_phase;
    } ctrl_t;

    state_t                 state;
    state_t                 state_next;
    ctrl_t                  dec;
    ctrl_t                  amo_wr_uop;
    ctrl_t                  ctrl_q;
    ctrl_t                  ctrl_out;
    logic                   dec_amo;
    logic                   dec_illegal;
    logic                   out_valid_q;
    logic                   suppress_q;
    logic [ILL_CNT_W-1:0]   ill_q;
    logic                   accept;
    logic                   hand_off;
    logic                   unused_instr_bits;

    // Only the opcode field matters to this stage.
    assign unused_instr_bits = ^instr[31:7];

    assign in_ready = ~flush & (state == RUN) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign hand_off = out_valid_q & out_ready;

    // Second half of a split atomic: the memory write.
    always_comb begin
        amo_wr_uop           = '0;
        amo_wr_uop.mem_write = 1'b1;
        amo_wr_uop.is_atomic = 1'b1;
        amo_wr_uop.uop_phase = 1'b1;
    end

    // Opcode decode of the incoming word; illegal words keep alu_op=11 and
    // only flag invalid_inst when not hidden by a compressed bubble or flush.
    always_comb begin
        dec         = '0;
        dec_amo     = 1'b0;
        dec_illegal = 1'b0;
        case (instr[6:0])
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.r_type    = 1'b1;
                dec.alu_op    = 2'b11;
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 2'b01;
            end
            OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_write      = 1'b1;
                dec.alu_src        = 1'b1;
                dec.mem_csr_to_reg = 2'b01;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu_op = 2'b10;
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.jump      = 1'b1;
                dec.jal       = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.lui       = 1'b1;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.auipc     = 1'b1;
            end
            OP_SYSTEM: begin
                if (EN_CSR != 0) begin
                    dec.reg_write      = 1'b1;
                    dec.csr_type       = 1'b1;
                    dec.mem_csr_to_reg = 2'b10;
                    dec.alu_op         = 2'b11;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_AMO: begin
                if (EN_ATOMIC != 0) begin
                    dec_amo       = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.is_atomic = 1'b1;
                    if (AMO_SPLIT != 0) begin
                        dec.mem_csr_to_reg = 2'b01;
                    end
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        if (dec_illegal) begin
            dec              = '0;
            dec.alu_op       = 2'b11;
            dec.invalid_inst = ~(stall_compressed | suppress_q);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: enter AMO_WR on a split atomic, leave once the read is taken.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN:     if (accept && dec_amo && (AMO_SPLIT != 0)) state_next = AMO_WR;
                AMO_WR:  if (hand_off) state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    // Output register, suppression flag and illegal counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            suppress_q  <= 1'b1;
            ill_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            suppress_q  <= 1'b1;
        end else if (state == AMO_WR) begin
            if (hand_off) begin
                ctrl_q <= amo_wr_uop;
            end
        end else if (accept) begin
            out_valid_q <= 1'b1;
            ctrl_q      <= dec;
            suppress_q  <= 1'b0;
            if (dec.invalid_inst && (ill_q != {ILL_CNT_W{1'b1}})) begin
                ill_q <= ill_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
        end
    end

    // Control outputs read as zero whenever the bundle is not valid.
    always_comb begin
        ctrl_out = '0;
        if (out_valid_q) begin
            ctrl_out = ctrl_q;
        end
    end

    assign out_valid      = out_valid_q;
    assign reg_write      = ctrl_out.reg_write;
    assign mem_write      = ctrl_out.mem_write;
    assign branch         = ctrl_out.branch;
    assign alu_src        = ctrl_out.alu_src;
    assign jump           = ctrl_out.jump;
    assign lui            = ctrl_out.lui;
    assign auipc          = ctrl_out.auipc;
    assign jal            = ctrl_out.jal;
    assign r_type         = ctrl_out.r_type;
    assign csr_type       = ctrl_out.csr_type;
    assign is_atomic      = ctrl_out.is_atomic;
    assign invalid_inst   = ctrl_out.invalid_inst;
    assign mem_csr_to_reg = ctrl_out.mem_csr_to_reg;
    assign alu_op         = ctrl_out.alu_op;
    assign uop_phase      = ctrl_out.uop_phase;
    assign ill_count      = ill_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: two instances (default parameters, and CSR off /
// single-uop atomics / 2-bit counter) share stimulus and are compared each
// cycle against a behavioural model of the decode stage.
module tb_decode_ctrl_pipe;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_AMO    = 7'b0101111;
    localparam logic [6:0] OP_ZERO   = 7'b0000000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic        stall_compressed;
    logic        out_ready;

    logic       in_ready_a, out_valid_a, reg_write_a, mem_write_a, branch_a, alu_src_a;
    logic       jump_a, lui_a, auipc_a, jal_a, r_type_a, csr_type_a, is_atomic_a, invalid_inst_a;
    logic [1:0] mem_csr_to_reg_a, alu_op_a;
    logic       uop_phase_a;
    logic [7:0] ill_count_a;

    logic       in_ready_b, out_valid_b, reg_write_b, mem_write_b, branch_b, alu_src_b;
    logic       jump_b, lui_b, auipc_b, jal_b, r_type_b, csr_type_b, is_atomic_b, invalid_inst_b;
    logic [1:0] mem_csr_to_reg_b, alu_op_b;
    logic       uop_phase_b;
    logic [1:0] ill_count_b;

    logic [16:0] bundle_a;
    logic [16:0] bundle_b;

    int err_count   = 0;
    int check_count = 0;

    // Reference model state, index 0 = default instance, 1 = variant instance.
    bit          m_valid [2];
    logic [16:0] m_bundle[2];
    bit          m_pend  [2];
    bit          m_sup   [2];
    int          m_cnt   [2];
    bit          p_csr   [2] = '{1'b1, 1'b0};
    bit          p_split [2] = '{1'b1, 1'b0};
    int          p_max   [2] = '{255, 3};

    always #5 clk = ~clk;

    assign bundle_a = {reg_write_a, mem_write_a, branch_a, alu_src_a, jump_a, lui_a, auipc_a, jal_a,
                       r_type_a, csr_type_a, is_atomic_a, invalid_inst_a, mem_csr_to_reg_a, alu_op_a, uop_phase_a};
    assign bundle_b = {reg_write_b, mem_write_b, branch_b, alu_src_b, jump_b, lui_b, auipc_b, jal_b,
                       r_type_b, csr_type_b, is_atomic_b, invalid_inst_b, mem_csr_to_reg_b, alu_op_b, uop_phase_b};

    decode_ctrl_pipe dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .instr(instr), .stall_compressed(stall_compressed), .out_valid(out_valid_a), .out_ready(out_ready),
        .reg_write(reg_write_a), .mem_write(mem_write_a), .branch(branch_a), .alu_src(alu_src_a),
        .jump(jump_a), .lui(lui_a), .auipc(auipc_a), .jal(jal_a), .r_type(r_type_a),
        .csr_type(csr_type_a), .is_atomic(is_atomic_a), .invalid_inst(invalid_inst_a),
        .mem_csr_to_reg(mem_csr_to_reg_a), .alu_op(alu_op_a), .uop_phase(uop_phase_a),
        .ill_count(ill_count_a)
    );

    decode_ctrl_pipe #(.EN_CSR(0), .EN_ATOMIC(1), .AMO_SPLIT(0), .ILL_CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .instr(instr), .stall_compressed(stall_compressed), .out_valid(out_valid_b), .out_ready(out_ready),
        .reg_write(reg_write_b), .mem_write(mem_write_b), .branch(branch_b), .alu_src(alu_src_b),
        .jump(jump_b), .lui(lui_b), .auipc(auipc_b), .jal(jal_b), .r_type(r_type_b),
        .csr_type(csr_type_b), .is_atomic(is_atomic_b), .invalid_inst(invalid_inst_b),
        .mem_csr_to_reg(mem_csr_to_reg_b), .alu_op(alu_op_b), .uop_phase(uop_phase_b),
        .ill_count(ill_count_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [16:0] pack(input bit rw, mw, br, as, jp, lu, au, jl, rt, cs, at, inv,
                                         input logic [1:0] wb, aop, input bit ph);
        return {rw, mw, br, as, jp, lu, au, jl, rt, cs, at, inv, wb, aop, ph};
    endfunction

    function automatic logic [16:0] ref_decode(input logic [6:0] op, input int k, input bit quiet);
        case (op)
            OP_R:      return pack(1,0,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b11, 0);
            OP_I:      return pack(1,0,0,1,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 0);
            OP_JALR:   return pack(1,0,0,1,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 0);
            OP_LOAD:   return pack(1,0,0,1,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 0);
            OP_STORE:  return pack(0,1,0,1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0);
            OP_BRANCH: return pack(0,0,1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 0);
            OP_JAL:    return pack(1,0,0,1,1,0,0,1,0,0,0,0, 2'b00, 2'b00, 0);
            OP_LUI:    return pack(1,0,0,1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 0);
            OP_AUIPC:  return pack(1,0,0,1,0,0,1,0,0,0,0,0, 2'b00, 2'b00, 0);
            OP_SYSTEM: if (p_csr[k]) return pack(1,0,0,0,0,0,0,0,0,1,0,0, 2'b10, 2'b11, 0);
            OP_AMO: begin
                if (p_split[k]) return pack(1,0,0,0,0,0,0,0,0,0,1,0, 2'b01, 2'b00, 0);
                else            return pack(1,0,0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 0);
            end
            default: ;
        endcase
        return pack(0,0,0,0,0,0,0,0,0,0,0,!quiet, 2'b00, 2'b11, 0);
    endfunction

    function automatic bit exp_ready(input int k);
        return !flush && !m_pend[k] && (!m_valid[k] || out_ready);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k]  = 0;
            m_bundle[k] = '0;
            m_pend[k]   = 0;
            m_sup[k]    = 1;
            m_cnt[k]    = 0;
        end
    endtask

    task automatic model_step();
        logic [16:0] b;
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                m_valid[k] = 0; m_bundle[k] = '0; m_pend[k] = 0; m_sup[k] = 1;
            end else if (m_pend[k]) begin
                if (m_valid[k] && out_ready) begin
                    m_bundle[k] = pack(0,1,0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 1);
                    m_pend[k]   = 0;
                end
            end else if (in_valid && exp_ready(k)) begin
                b = ref_decode(instr[6:0], k, m_sup[k] || stall_compressed);
                m_bundle[k] = b;
                m_valid[k]  = 1;
                m_sup[k]    = 0;
                if (b[5] && m_cnt[k] < p_max[k]) m_cnt[k]++;
                if (instr[6:0] == OP_AMO && p_split[k]) m_pend[k] = 1;
            end else if (out_ready) begin
                m_valid[k] = 0; m_bundle[k] = '0;
            end
        end
    endtask

    task automatic check_state();
        checkOutput("a.out_valid", 32'(out_valid_a), 32'(m_valid[0]));
        checkOutput("a.bundle",    32'(bundle_a),    32'(m_valid[0] ? m_bundle[0] : 17'd0));
        checkOutput("a.ill_count", 32'(ill_count_a), 32'(m_cnt[0]));
        checkOutput("b.out_valid", 32'(out_valid_b), 32'(m_valid[1]));
        checkOutput("b.bundle",    32'(bundle_b),    32'(m_valid[1] ? m_bundle[1] : 17'd0));
        checkOutput("b.ill_count", 32'(ill_count_b), 32'(m_cnt[1]));
    endtask

    // One cycle: drive at the falling edge, check in_ready, step model, check after the edge.
    task automatic applyStimulus(input bit v, input logic [6:0] op, input bit st, input bit fl, input bit rdy);
        in_valid         = v;
        instr            = {7'($urandom), 18'($urandom), op};
        stall_compressed = st;
        flush            = fl;
        out_ready        = rdy;
        #1;
        checkOutput("a.in_ready", 32'(in_ready_a), 32'(exp_ready(0)));
        checkOutput("b.in_ready", 32'(in_ready_b), 32'(exp_ready(1)));
        model_step();
        @(negedge clk);
        check_state();
    endtask

    logic [6:0] op_table[14] = '{OP_R, OP_I, OP_JALR, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
                                 OP_LUI, OP_AUIPC, OP_SYSTEM, OP_AMO, OP_AMO, OP_ZERO, 7'b1111111};

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0;
        stall_compressed = 1'b0; out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_state();
        checkOutput("a.in_ready_reset", 32'(in_ready_a), 32'(exp_ready(0)));
        reset_n = 1'b1;

        // Back-to-back R, LOAD, STORE.
        applyStimulus(1, OP_R, 0, 0, 1);
        applyStimulus(1, OP_LOAD, 0, 0, 1);
        applyStimulus(1, OP_STORE, 0, 0, 1);
        applyStimulus(0, OP_R, 0, 0, 1);

        // Branch held under backpressure.
        applyStimulus(1, OP_BRANCH, 0, 0, 1);
        repeat (3) applyStimulus(1, OP_R, 0, 0, 0);
        applyStimulus(1, OP_R, 0, 0, 1);
        applyStimulus(0, OP_R, 0, 0, 1);

        // Atomic split, then atomic flushed in its write phase.
        applyStimulus(1, OP_AMO, 0, 0, 1);
        applyStimulus(1, OP_I, 0, 0, 1);
        applyStimulus(1, OP_I, 0, 0, 1);
        applyStimulus(1, OP_AMO, 0, 0, 1);
        applyStimulus(0, OP_R, 0, 1, 0);
        applyStimulus(1, OP_ZERO, 0, 0, 1);
        applyStimulus(1, OP_ZERO, 0, 0, 1);

        // CSR disabled on the variant, counter saturation, compressed bubble.
        applyStimulus(1, OP_SYSTEM, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, OP_ZERO, 0, 0, 1);
        applyStimulus(1, 7'b1111111, 1, 0, 1);
        applyStimulus(0, OP_R, 0, 0, 1);

        // Asynchronous reset while a bundle is held.
        applyStimulus(1, OP_LOAD, 0, 0, 0);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("a.async_out_valid", 32'(out_valid_a), 32'd0);
        checkOutput("a.async_bundle",    32'(bundle_a),    32'd0);
        checkOutput("a.async_ill_count", 32'(ill_count_a), 32'd0);
        checkOutput("b.async_ill_count", 32'(ill_count_b), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        check_state();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          op_table[$urandom_range(0, 13)],
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
